lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit sitting between the execute stage and data_mem_top.
//  - Stores: builds the byte mask and replicates the store data across lanes.
//  - Loads: waits for the memory valid, then byte/half extracts and sign/zero-extends the word.
//  - One outstanding access; valid/ready toward execute, single-cycle response pulse toward writeback.
// PARAMETERS
//  Address  8   word-address width driven to data memory (byte address bits [Address+1:2])
//  TIMEOUT  15  max cycles in WAIT without dm_valid before error response (>=2)
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   execute presents a memory op
//  req_ready    out  1   LSU can accept (state==IDLE)
//  req_store    in   1   1=store, 0=load
//  req_funct3   in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32  byte address from ALU
//  req_wdata    in   32  rs2 value for stores
//  dm_request   out  1   memory request strobe
//  dm_we_re     out  1   1=write, 0=read
//  dm_load      out  1   load strobe; memory returns dm_valid one cycle later
//  dm_mask      out  4   byte lane enables
//  dm_address   out  Address  word address
//  dm_data_in   out  32  lane-replicated store data
//  dm_valid     in   1   load data valid
//  dm_data_out  in   32  raw word from memory
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  extended load data (0 for stores/errors)
//  rsp_err      out  1   illegal funct3, timeout or misaligned (with trap)
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; all dm_* and rsp_* outputs 0; timeout counter 0.
//    Reset mid-operation drops the transaction; no rsp_valid is produced.
//  - Handshake: accept when req_valid & req_ready. Address, funct3, store flag and wdata
//    are registered at acceptance; later req_* changes are ignored.
//  - FSM:
//    IDLE->ISSUE on accept (legal op).
//    IDLE->RESP on accept with illegal funct3 (011, 110, 111; or 100/101 on a store).
//      No memory access; rsp_err=1.
//    ISSUE: dm_request=1 for exactly one cycle.
//      Store: dm_we_re=1 -> RESP.
//      Load: dm_load=1 -> WAIT.
//    WAIT: dm_valid=1 -> capture dm_data_out, -> RESP.
//      Counter reaching TIMEOUT -> RESP with rsp_err=1, rsp_rdata=0.
//    RESP: rsp_valid=1 for one cycle -> IDLE.
//  - Latency (accept cycle T): load rsp_valid at T+3; store rsp_valid at T+2; illegal op at T+1.
//    Back-to-back throughput is one op per 3 (load) or 2 (store) cycles plus the accept cycle.
//  - dm_* are 0 outside ISSUE. dm_valid outside WAIT is ignored.
//  - Mask, with o=addr[1:0]:
//    B: 4'b0001<<o.
//    H: 4'b0011<<{o[1],1'b0}.
//    W: 4'b1111.
//  - Store data: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
//  - Load extract: byte lane o, or half o[1]; sign-extend for B/H, zero-extend for BU/HU.
//  - dm_address = addr[Address+1:2]; upper byte-address bits are ignored (wrap-around).
//  - TIMEOUT counter is cleared on entry to WAIT and saturates; it never wraps.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    H with addr[0]=1, or W with addr[1:0]!=0, goes IDLE->RESP with rsp_err=1.
//    No memory access.
//  MISALIGN_TRAP_EN undefined:
//    Misaligned low bits are forced to natural alignment (H clears bit0, W clears [1:0]).
//    The access proceeds normally.
// TESTING
//  1. SW addr=0x10, wdata=0xDEADBEEF -> T+1: dm_address=4, mask=1111, we_re=1;
//     T+2: rsp_valid=1, err=0.
//  2. SB addr=0x13, wdata=0x000000A5 -> mask=1000, dm_data_in=0xA5A5A5A5.
//  3. LB addr=0x11 with dm_data_out=0x1234_80FF, dm_valid at T+2 -> rsp_rdata=0xFFFFFF80 at T+3.
//     Same access as LBU -> 0x00000080.
//  4. LH addr=0x2 on the same data -> 0x00001234.
//     LH addr=0x3: with MISALIGN_TRAP_EN, rsp_err=1 at T+1 with no dm_request;
//     without it, 0x00001234.
//  5. Load with dm_valid never asserted -> rsp_valid=1, rsp_err=1 after 15 WAIT cycles;
//     req_ready=0 throughout.
//  6. rst=1 during WAIT -> next cycle IDLE, req_ready=1, no rsp_valid;
//     funct3=011 -> rsp_err=1 at T+1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between execute and data memory.
// One access in flight. Stores build a byte mask and replicate the store
// data across lanes. Loads wait for dm_valid, then extract and extend the
// addressed byte or half. A one-cycle rsp_valid pulse reports completion.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word accesses respond with rsp_err and never touch memory. When it
// is undefined, the low address bits are forced to natural alignment.
module lsu_ctrl #(
  parameter int Address = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_store,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               dm_request,
  output logic               dm_we_re,
  output logic               dm_load,
  output logic [3:0]         dm_mask,
  output logic [Address-1:0] dm_address,
  output logic [31:0]        dm_data_in,
  input  logic               dm_valid,
  input  logic [31:0]        dm_data_out,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               err_p0;
  logic               store_p0;
  logic [2:0]         f3_p0;
  logic [Address+1:0] addr_p0;
  logic [31:0]        wdata_p0;
  logic [31:0]        rdata_p0;
  logic               accept;
  logic               misalign;
  logic               issue;
  logic               unused_addr_hi;

  // Byte-address bits above the word address wrap around and are dropped.
  assign unused_addr_hi = ^req_addr[31:Address+2];

  // Width/sign encodings the LSU understands; BU/HU exist only for loads.
  function automatic logic op_illegal(input logic st, input logic [2:0] f3);
    logic bad;
    case (f3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = st;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte lanes touched; a halfword always sits on an even lane pair.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] o);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << o;
      2'b01:   m = 4'b0011 << {o[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate narrow store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{w[7:0]}};
      2'b01:   r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half from the raw word and sign/zero-extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept = req_valid && (state == S_IDLE);
  assign issue  = (state == S_ISSUE);

  // Control FSM: accept, issue one memory strobe, wait for data, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      err_p0   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_illegal(req_store, req_funct3) || misalign) begin
              state  <= S_RESP;
              err_p0 <= 1'b1;
            end else begin
              state  <= S_ISSUE;
              err_p0 <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          state    <= store_p0 ? S_RESP : S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (dm_valid) begin
            state <= S_RESP;
          end else if (wait_cnt >= CNT_W'(TIMEOUT - 1)) begin
            state  <= S_RESP;
            err_p0 <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request capture at acceptance; load result captured when memory answers.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_p0 <= req_store;
      f3_p0    <= req_funct3;
      addr_p0  <= req_addr[Address+1:0];
      wdata_p0 <= req_wdata;
      rdata_p0 <= '0;
    end else if ((state == S_WAIT) && dm_valid) begin
      rdata_p0 <= load_ext(f3_p0, addr_p0[1:0], dm_data_out);
    end
  end

  // Outputs decode from state so they are quiet outside ISSUE/RESP.
  always_comb begin
    req_ready  = (state == S_IDLE);
    dm_request = issue;
    dm_we_re   = issue && store_p0;
    dm_load    = issue && !store_p0;
    dm_mask    = issue ? lane_mask(f3_p0[1:0], addr_p0[1:0]) : 4'b0000;
    dm_address = issue ? addr_p0[Address+1:2] : '0;
    dm_data_in = (issue && store_p0) ? store_rep(f3_p0[1:0], wdata_p0) : 32'd0;
    rsp_valid  = (state == S_RESP);
    rsp_rdata  = (state == S_RESP) ? rdata_p0 : 32'd0;
    rsp_err    = (state == S_RESP) && err_p0;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed vector table, hand-written corner
// sequences (timeout, late dm_valid, reset mid-load) and randomized ops
// against an arithmetic reference model. Honours MISALIGN_TRAP_EN.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        dm_request;
  logic        dm_we_re;
  logic        dm_load;
  logic [3:0]  dm_mask;
  logic [7:0]  dm_address;
  logic [31:0] dm_data_in;
  logic        dm_valid;
  logic [31:0] dm_data_out;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.Address(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .dm_request(dm_request), .dm_we_re(dm_we_re), .dm_load(dm_load),
    .dm_mask(dm_mask), .dm_address(dm_address), .dm_data_in(dm_data_in),
    .dm_valid(dm_valid), .dm_data_out(dm_data_out),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    logic        acc;
    logic [3:0]  mask;
    logic [31:0] din;
    logic [7:0]  waddr;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    int          nreq;
    logic [3:0]  mask;
    logic [31:0] din;
    logic [7:0]  waddr;
    logic        we;
    logic        ld;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        ready_ok;
    logic        idle_ok;
    logic        after_ok;
  } obs_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
    end
  endfunction

  // Reference model: lanes and values computed from access size and offset.
  function automatic vec_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] mem);
    vec_t   e;
    int     size, off, base;
    logic   legal, trap;
    longint val;
    e = '{default: 0};
    e.st = st; e.f3 = f3; e.addr = addr; e.wdata = wdata; e.mem = mem;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    off   = int'(addr % 4);
`ifdef MISALIGN_TRAP_EN
    trap = (off % size) != 0;
`else
    trap = 1'b0;
`endif
    if (!legal || trap) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    base = (off / size) * size;
    for (int i = 0; i < 4; i++) begin
      e.mask[i] = (i >= base) && (i < base + size);
      e.din[8*i +: 8] = wdata[8*(i % size) +: 8];
    end
    e.waddr = 8'((addr / 4) % 256);
    e.acc = 1'b1;
    if (st) begin
      e.lat = 2;
    end else begin
      val = (longint'(mem) >> (8 * base)) & ((longint'(1) << (8 * size)) - 1);
      if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
        val = val - (longint'(1) << (8 * size));
      e.rdata = val[31:0];
      e.lat = 3;
    end
    return e;
  endfunction

  // Present one op at a negedge, then watch until the response (bounded).
  task automatic run_op(input vec_t v, input int dly, output obs_t o);
    int  ld_cyc;
    bit  done;
    o = '{default: 0};
    o.ready_ok = 1'b1; o.idle_ok = 1'b1;
    ld_cyc = -1;
    done = 1'b0;
    req_valid = 1'b1; req_store = v.st; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      dm_valid = (dly >= 0) && (ld_cyc > 0) && (cyc == ld_cyc + 1 + dly);
      dm_data_out = dm_valid ? v.mem : $urandom;
      if (req_ready) o.ready_ok = 1'b0;
      if (dm_request) begin
        o.nreq++;
        o.mask = dm_mask; o.din = dm_data_in; o.waddr = dm_address;
        o.we = dm_we_re; o.ld = dm_load;
        if (dm_load) ld_cyc = cyc;
      end else if (dm_mask != 0 || dm_we_re || dm_load || dm_address != 0 || dm_data_in != 0) begin
        o.idle_ok = 1'b0;
      end
      if (rsp_valid) begin
        o.lat = cyc; o.rdata = rsp_rdata; o.err = rsp_err;
        done = 1'b1;
      end else if (rsp_err || rsp_rdata != 0) begin
        o.idle_ok = 1'b0;
      end
      @(negedge clk);
    end
    dm_valid = 1'b0;
    o.after_ok = !rsp_valid && req_ready;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int dly, input vec_t e);
    obs_t o;
    run_op(v, dly, o);
    check({tag, ".lat"},   o.lat, e.lat);
    check({tag, ".err"},   o.err, e.err);
    check({tag, ".rdata"}, o.rdata, e.rdata);
    check({tag, ".busy"},  o.ready_ok, 1'b1);
    check({tag, ".quiet"}, o.idle_ok, 1'b1);
    check({tag, ".after"}, o.after_ok, 1'b1);
    check({tag, ".nreq"},  o.nreq, e.acc ? 1 : 0);
    if (e.acc) begin
      check({tag, ".mask"},  o.mask, e.mask);
      check({tag, ".waddr"}, o.waddr, e.waddr);
      check({tag, ".we"},    o.we, e.st);
      check({tag, ".ld"},    o.ld, !e.st);
      if (e.st) check({tag, ".din"}, o.din, e.din);
    end
  endtask

  vec_t tbl [15];
  vec_t v, e;
  logic ok;
  int   dly;

  initial begin
    // st f3 addr wdata mem | acc mask din waddr rdata err lat
    tbl[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b1, 4'hF, 32'hDEADBEEF, 8'h04, 32'h0, 1'b0, 2};
    tbl[1]  = '{1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b1, 4'h8, 32'hA5A5A5A5, 8'h04, 32'h0, 1'b0, 2};
    tbl[2]  = '{1'b0, 3'b000, 32'h11, 32'h0, 32'h123480FF, 1'b1, 4'h2, 32'h0, 8'h04, 32'hFFFFFF80, 1'b0, 3};
    tbl[3]  = '{1'b0, 3'b100, 32'h11, 32'h0, 32'h123480FF, 1'b1, 4'h2, 32'h0, 8'h04, 32'h00000080, 1'b0, 3};
    tbl[4]  = '{1'b0, 3'b001, 32'h02, 32'h0, 32'h123480FF, 1'b1, 4'hC, 32'h0, 8'h00, 32'h00001234, 1'b0, 3};
`ifdef MISALIGN_TRAP_EN
    tbl[5]  = '{1'b0, 3'b001, 32'h03, 32'h0, 32'h123480FF, 1'b0, 4'h0, 32'h0, 8'h00, 32'h0, 1'b1, 1};
    tbl[13] = '{1'b1, 3'b010, 32'h21, 32'h01020304, 32'h0, 1'b0, 4'h0, 32'h0, 8'h00, 32'h0, 1'b1, 1};
`else
    tbl[5]  = '{1'b0, 3'b001, 32'h03, 32'h0, 32'h123480FF, 1'b1, 4'hC, 32'h0, 8'h00, 32'h00001234, 1'b0, 3};
    tbl[13] = '{1'b1, 3'b010, 32'h21, 32'h01020304, 32'h0, 1'b1, 4'hF, 32'h01020304, 8'h08, 32'h0, 1'b0, 2};
`endif
    tbl[6]  = '{1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 8'h00, 32'h0, 1'b1, 1};
    tbl[7]  = '{1'b1, 3'b100, 32'h40, 32'h55, 32'h0, 1'b0, 4'h0, 32'h0, 8'h00, 32'h0, 1'b1, 1};
    tbl[8]  = '{1'b1, 3'b111, 32'h40, 32'h55, 32'h0, 1'b0, 4'h0, 32'h0, 8'h00, 32'h0, 1'b1, 1};
    tbl[9]  = '{1'b1, 3'b001, 32'h106, 32'h1234ABCD, 32'h0, 1'b1, 4'hC, 32'hABCDABCD, 8'h41, 32'h0, 1'b0, 2};
    tbl[10] = '{1'b0, 3'b010, 32'h12345678, 32'h0, 32'hCAFEF00D, 1'b1, 4'hF, 32'h0, 8'h9E, 32'hCAFEF00D, 1'b0, 3};
    tbl[11] = '{1'b0, 3'b001, 32'h0, 32'h0, 32'h0000F00D, 1'b1, 4'h3, 32'h0, 8'h00, 32'hFFFFF00D, 1'b0, 3};
    tbl[12] = '{1'b0, 3'b101, 32'h0, 32'h0, 32'h0000F00D, 1'b1, 4'h3, 32'h0, 8'h00, 32'h0000F00D, 1'b0, 3};
    tbl[14] = '{1'b0, 3'b000, 32'h03, 32'h0, 32'h7F000000, 1'b1, 4'h8, 32'h0, 8'h00, 32'h0000007F, 1'b0, 3};

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; dm_valid = 1'b0; dm_data_out = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ready", req_ready, 1'b1);
    check("reset.quiet", {dm_request, dm_we_re, dm_load, dm_mask, dm_address, rsp_valid, rsp_err},
          17'd0 | {1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0});
    check("reset.data", dm_data_in | rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      check_vec($sformatf("tbl%0d", i), tbl[i], 0, tbl[i]);

    // Memory never answers: error after 15 WAIT cycles, busy the whole time.
    v = '{1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b1, 4'hF, 32'h0, 8'h08, 32'h0, 1'b1, 17};
    check_vec("timeout", v, -1, v);

    // Memory answers late; latency stretches by the delay.
    v = '{1'b0, 3'b000, 32'h11, 32'h0, 32'h123480FF, 1'b1, 4'h2, 32'h0, 8'h04, 32'hFFFFFF80, 1'b0, 8};
    check_vec("late", v, 5, v);

    // Reset while waiting drops the load without a response.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstwait.busy", req_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstwait.ready", req_ready, 1'b1);
    check("rstwait.rsp", rsp_valid, 1'b0);
    check("rstwait.req", dm_request, 1'b0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      dm_valid = 1'b1; dm_data_out = $urandom;
      @(negedge clk);
      if (rsp_valid || !req_ready) ok = 1'b0;
    end
    dm_valid = 1'b0;
    check("rstwait.silent", ok, 1'b1);

    // Randomized ops against the reference model.
    for (int n = 0; n < 80; n++) begin
      v = model(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
      dly = $urandom_range(0, 3);
      e = v;
      if (e.acc && !e.st) e.lat = e.lat + dly;
      check_vec($sformatf("rnd%0d", n), v, dly, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
